// File: rtl/prim_cmp_share_pkg.sv
// Shared definitions for the shared-comparator scheduler: FSM encoding and datapath widths.
package prim_cmp_share_pkg;

  localparam int CMP_W = 24;
  localparam int OP_W  = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    RESP = 2'd3
  } cmp_share_state_e;

endpackage

// File: rtl/prim_arb_rr.sv
// Round-robin arbiter: first active request at or after ptr, wrapping, wins.
module prim_arb_rr #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_gnt_id,
  output logic           o_gnt_valid
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    o_gnt       = '0;
    o_gnt_id    = '0;
    o_gnt_valid = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, i_ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N)) begin
        sum = sum - (IDW+1)'(N);
      end
      idx = sum[IDW-1:0];
      if (!o_gnt_valid && i_req[idx]) begin
        o_gnt[idx]  = 1'b1;
        o_gnt_id    = idx;
        o_gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prim_cmp_mag_24bit.sv
// 24-bit magnitude comparator; signed mode flips the sign bit so one unsigned compare serves both.
module prim_cmp_mag_24bit
  import prim_cmp_share_pkg::*;
(
  input  logic [CMP_W-1:0] i_a,
  input  logic [CMP_W-1:0] i_b,
  input  logic             i_signed_en,
  output logic             o_eq,
  output logic             o_gt,
  output logic             o_lt
);

  logic [CMP_W-1:0] a_k;
  logic [CMP_W-1:0] b_k;

  always_comb begin
    a_k  = {i_a[CMP_W-1] ^ i_signed_en, i_a[CMP_W-2:0]};
    b_k  = {i_b[CMP_W-1] ^ i_signed_en, i_b[CMP_W-2:0]};
    o_eq = (a_k == b_k);
    o_gt = (a_k > b_k);
    o_lt = (a_k < b_k);
  end

endmodule

// File: rtl/prim_cmp_share_ctrl.sv
// Schedules NUM_REQ requesters onto one 24-bit comparator, doing 48-bit compares high word first.
// PRIM_CMP_SHARE_EARLY_EXIT_EN enables the HI->RESP shortcut when the high words already differ.
module prim_cmp_share_ctrl
  import prim_cmp_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ-1:0][OP_W-1:0]   i_req_a,
  input  logic [NUM_REQ-1:0][OP_W-1:0]   i_req_b,
  input  logic [NUM_REQ-1:0]             i_req_signed,
  output logic                           o_rsp_valid,
  output logic [ID_W-1:0]                o_rsp_id,
  output logic                           o_rsp_eq,
  output logic                           o_rsp_gt,
  output logic                           o_rsp_lt,
  input  logic                           i_rsp_ready,
  output cmp_share_state_e               o_dbg_state
);

  // Request side: o_req_ready[g] is high only in IDLE for the granted requester; a
  // request transfers on the edge where valid and ready are both high. Response side:
  // o_rsp_valid stays high with id/flags held until the edge where i_rsp_ready is high.

  cmp_share_state_e  state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic              sgn_q, sgn_d;
  logic              eq_q, eq_d;
  logic              gt_q, gt_d;
  logic              lt_q, lt_d;
`ifndef PRIM_CMP_SHARE_EARLY_EXIT_EN
  logic              hi_diff_q, hi_diff_d;
  logic              hi_gt_q, hi_gt_d;
  logic              hi_lt_q, hi_lt_d;
`endif

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;

  logic [CMP_W-1:0]   cmp_a;
  logic [CMP_W-1:0]   cmp_b;
  logic               cmp_signed;
  logic               cmp_eq;
  logic               cmp_gt;
  logic               cmp_lt;

  prim_arb_rr #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_arb (
    .i_req       (i_req_valid),
    .i_ptr       (ptr_q),
    .o_gnt       (gnt),
    .o_gnt_id    (gnt_id),
    .o_gnt_valid (gnt_valid)
  );

  // Low word is the magnitude part of the operand, so only the high pass is signed.
  always_comb begin
    if (state_q == HI) begin
      cmp_a      = a_q[OP_W-1:CMP_W];
      cmp_b      = b_q[OP_W-1:CMP_W];
      cmp_signed = sgn_q;
    end else begin
      cmp_a      = a_q[CMP_W-1:0];
      cmp_b      = b_q[CMP_W-1:0];
      cmp_signed = 1'b0;
    end
  end

  prim_cmp_mag_24bit u_cmp (
    .i_a         (cmp_a),
    .i_b         (cmp_b),
    .i_signed_en (cmp_signed),
    .o_eq        (cmp_eq),
    .o_gt        (cmp_gt),
    .o_lt        (cmp_lt)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
`ifndef PRIM_CMP_SHARE_EARLY_EXIT_EN
    hi_diff_d = hi_diff_q;
    hi_gt_d   = hi_gt_q;
    hi_lt_d   = hi_lt_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          a_d     = i_req_a[gnt_id];
          b_d     = i_req_b[gnt_id];
          sgn_d   = i_req_signed[gnt_id];
          id_d    = gnt_id;
          state_d = HI;
        end
      end
      HI: begin
`ifdef PRIM_CMP_SHARE_EARLY_EXIT_EN
        if (!cmp_eq) begin
          eq_d    = 1'b0;
          gt_d    = cmp_gt;
          lt_d    = cmp_lt;
          state_d = RESP;
        end else begin
          state_d = LO;
        end
`else
        hi_diff_d = !cmp_eq;
        hi_gt_d   = cmp_gt;
        hi_lt_d   = cmp_lt;
        state_d   = LO;
`endif
      end
      LO: begin
`ifdef PRIM_CMP_SHARE_EARLY_EXIT_EN
        eq_d = cmp_eq;
        gt_d = cmp_gt;
        lt_d = cmp_lt;
`else
        if (hi_diff_q) begin
          eq_d = 1'b0;
          gt_d = hi_gt_q;
          lt_d = hi_lt_q;
        end else begin
          eq_d = cmp_eq;
          gt_d = cmp_gt;
          lt_d = cmp_lt;
        end
`endif
        state_d = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          ptr_d   = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
`ifndef PRIM_CMP_SHARE_EARLY_EXIT_EN
      hi_diff_q <= 1'b0;
      hi_gt_q   <= 1'b0;
      hi_lt_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
`ifndef PRIM_CMP_SHARE_EARLY_EXIT_EN
      hi_diff_q <= hi_diff_d;
      hi_gt_q   <= hi_gt_d;
      hi_lt_q   <= hi_lt_d;
`endif
    end
  end

  assign o_req_ready = (state_q == IDLE) ? gnt : '0;
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_id    = id_q;
  assign o_rsp_eq    = eq_q;
  assign o_rsp_gt    = gt_q;
  assign o_rsp_lt    = lt_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_prim_cmp_share_ctrl.sv
// Directed bench for prim_cmp_share_ctrl with a grant-time scoreboard of {id, eq, gt, lt}.
module tb_prim_cmp_share_ctrl;
  import prim_cmp_share_pkg::*;

  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int W   = IDW + 3;
`ifdef PRIM_CMP_SHARE_EARLY_EXIT_EN
  localparam int LAT_DIFF = 2;
`else
  localparam int LAT_DIFF = 3;
`endif
  localparam int LAT_FULL = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][47:0]    req_a;
  logic [NR-1:0][47:0]    req_b;
  logic [NR-1:0]          req_signed;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_eq, rsp_gt, rsp_lt;
  logic                   rsp_ready;
  cmp_share_state_e       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];
  int           rsp_ids[$];

  prim_cmp_share_ctrl #(.NUM_REQ(NR), .ID_W(IDW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_req_signed (req_signed),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_rsp_eq     (rsp_eq),
    .o_rsp_gt     (rsp_gt),
    .o_rsp_lt     (rsp_lt),
    .i_rsp_ready  (rsp_ready),
    .o_dbg_state  (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference: full 48-bit compare, returns {eq, gt, lt}
  function automatic logic [2:0] model(logic [47:0] a, logic [47:0] b, logic s);
    if (a == b) return 3'b100;
    if (s) return ($signed(a) > $signed(b)) ? 3'b010 : 3'b001;
    return (a > b) ? 3'b010 : 3'b001;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: push at grant, pop at response handshake
  always @(negedge clk) begin
    if (!rst) begin
      check("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          exp_q.push_back({IDW'(i), model(req_a[i], req_b[i], req_signed[i])});
        end
      end
      if (rsp_valid) begin
        check("rsp_flags_onehot", 64'($onehot({rsp_eq, rsp_gt, rsp_lt})), 64'd1);
        if (rsp_ready) begin
          check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            check("sb_rsp", 64'({rsp_id, rsp_eq, rsp_gt, rsp_lt}), 64'(exp_q.pop_front()));
          end
          rsp_ids.push_back(int'(rsp_id));
        end
      end
    end
  end

  // driver tasks; inputs change 1 time unit after a rising edge
  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drive_op(int id, logic [47:0] a, logic [47:0] b, logic s);
    req_a[id]      = a;
    req_b[id]      = b;
    req_signed[id] = s;
    req_valid[id]  = 1'b1;
  endtask

  task automatic wait_accept(int id, output int acc);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1;
    end
    check("accept_timeout", 64'(got), 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output int seen);
    bit got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    check("rsp_timeout", 64'(got), 64'd1);
    seen = cyc;
  endtask

  task automatic run_single(string tag, int id, logic [47:0] a, logic [47:0] b, logic s,
                            int lat, logic [2:0] flags);
    int acc, seen;
    drive_op(id, a, b, s);
    wait_accept(id, acc);
    wait_rsp(seen);
    check({tag, "_lat"}, 64'(seen - acc), 64'(lat));
    check({tag, "_rsp"}, 64'({rsp_id, rsp_eq, rsp_gt, rsp_lt}), 64'({IDW'(id), flags}));
    @(posedge clk); #1;
  endtask

  initial begin : main
    logic [63:0] r;
    logic [47:0] ra, rb;
    logic        rs;
    int          rid, acc, seen, cnt;
    logic [W-1:0] snap;
    bit          got;

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    rsp_ready  = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_flags", 64'({rsp_eq, rsp_gt, rsp_lt}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // directed compares
    run_single("hi_gt", 0, 48'h000001_000000, 48'h000000_FFFFFF, 1'b0, LAT_DIFF, 3'b010);
    run_single("lo_lt", 0, 48'h123456_000010, 48'h123456_000020, 1'b0, LAT_FULL, 3'b001);
    run_single("eq",    0, 48'hABCDEF_012345, 48'hABCDEF_012345, 1'b0, LAT_FULL, 3'b100);
    run_single("sgn_lt", 0, 48'hFFFFFF_FFFFFF, 48'h000000_000001, 1'b1, LAT_DIFF, 3'b001);
    run_single("uns_gt", 0, 48'hFFFFFF_FFFFFF, 48'h000000_000001, 1'b0, LAT_DIFF, 3'b010);
    run_single("sgn_lo", 3, 48'hFFFFFF_000001, 48'hFFFFFF_FFFFFF, 1'b1, LAT_FULL, 3'b001);

    // random single ops on random requesters
    for (int k = 0; k < 8; k++) begin
      rid = $urandom_range(0, NR-1);
      r = {$urandom(), $urandom()};
      ra = r[47:0];
      r = {$urandom(), $urandom()};
      rb = r[47:0];
      if (k % 2 == 1) rb[47:24] = ra[47:24];
      rs = 1'($urandom_range(0, 1));
      run_single("rand", rid, ra, rb, rs, (ra[47:24] != rb[47:24]) ? LAT_DIFF : LAT_FULL,
                 model(ra, rb, rs));
    end

    // round robin with all requesters continuously valid
    do_reset();
    rsp_ids.delete();
    for (int i = 0; i < NR; i++) begin
      r = {$urandom(), $urandom()};
      drive_op(i, r[47:0], {r[23:0], r[47:24]}, 1'($urandom_range(0, 1)));
    end
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (rsp_ids.size() >= 6) got = 1;
    end
    check("rr_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    for (int i = 0; i < 6 && i < rsp_ids.size(); i++) begin
      check("rr_id", 64'(rsp_ids[i]), 64'(i % NR));
    end

    // response back-pressure for 5 cycles while requester 1 waits
    do_reset();
    rsp_ready = 1'b0;
    drive_op(0, 48'h00ABCD_000005, 48'h00ABCD_000003, 1'b0);
    drive_op(1, 48'h000000_000007, 48'h000000_000007, 1'b0);
    wait_accept(0, acc);
    wait_rsp(seen);
    snap = {rsp_id, rsp_eq, rsp_gt, rsp_lt};
    check("stall_rsp", 64'(snap), 64'({2'd0, 3'b010}));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_hold", 64'({rsp_id, rsp_eq, rsp_gt, rsp_lt}), 64'(snap));
      check("stall_ready0", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_valid6", 64'(rsp_valid), 64'd1);
    check("stall_ready6", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("stall_next_grant", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(seen);
    check("stall_next_rsp", 64'({rsp_id, rsp_eq, rsp_gt, rsp_lt}), 64'({2'd1, 3'b100}));
    @(posedge clk); #1;

    // reset while in LO drops the op; afterwards requester 0 wins over 2
    do_reset();
    drive_op(0, 48'h333333_000001, 48'h333333_000002, 1'b0);
    drive_op(2, 48'h000000_000009, 48'h000000_000001, 1'b0);
    req_valid[2] = 1'b0;
    wait_accept(0, acc);
    check("rstlo_hi", 64'(dbg_state), 64'(HI));
    @(posedge clk); #1;
    check("rstlo_lo", 64'(dbg_state), 64'(LO));
    rst       = 1'b1;
    req_valid = 4'b0101;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    rsp_ids.delete();
    check("rstlo_idle", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    check("rstlo_no_rsp", 64'(rsp_valid), 64'd0);
    check("rstlo_grant0", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    got = 0;
    cnt = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (req_ready[2] && req_valid[2]) begin
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
      end
      if (rsp_ids.size() >= 2) got = 1;
    end
    check("rstlo_timeout", 64'(got), 64'd1);
    if (rsp_ids.size() >= 2) begin
      check("rstlo_first_id", 64'(rsp_ids[0]), 64'd0);
      check("rstlo_second_id", 64'(rsp_ids[1]), 64'd2);
    end
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prim_cmp_share_ctrl.md
# prim_cmp_share_ctrl

Shared-comparator scheduler. It arbitrates up to NUM_REQ requesters onto one prim_cmp_mag_24bit instance and performs 48-bit signed/unsigned magnitude compares in two 24-bit passes: high word first, then low word. It sits beside the execute/branch datapath wherever several units need wide compares but only one comparator is budgeted. It returns a single eq/gt/lt result, tagged with the requester id, over a valid/ready response channel.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- ID_W, default $clog2(NUM_REQ): requester id width.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- o_req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- i_req_a  in  NUM_REQ x 48  operand A per requester.
- i_req_b  in  NUM_REQ x 48  operand B per requester.
- i_req_signed  in  NUM_REQ  1 = two's-complement compare.
- o_rsp_valid  out  1  result valid.
- o_rsp_id  out  ID_W  id of the requester the result belongs to.
- o_rsp_eq / o_rsp_gt / o_rsp_lt  out  1 each  result flags, exactly one set when valid.
- i_rsp_ready  in  1  consumer accepts result.

## Operation
- FSM states: IDLE, HI, LO, RESP.
- IDLE:
  - If any i_req_valid, grant by round-robin starting at ptr.
  - o_req_ready[g] = 1 combinationally, for the grant only.
  - Latch a, b, signed, and id. Go to HI.
  - No valid: stay in IDLE, all ready = 0.
- HI:
  - Comparator gets a[47:24], b[47:24], i_signed_en = latched signed.
  - If high words differ: register gt/lt, go to RESP (early exit).
  - Else go to LO.
- LO:
  - Comparator gets a[23:0], b[23:0], i_signed_en = 0. The low word is always unsigned.
  - Register eq/gt/lt. Go to RESP.
- RESP:
  - o_rsp_valid = 1. Hold id and flags stable until i_rsp_ready.
  - On handshake: ptr = granted id + 1, wrapping NUM_REQ-1 to 0. Go to IDLE.
- Only one operation is in flight. o_req_ready is 0 in HI, LO, and RESP.
- i_rsp_ready is ignored outside RESP.
- A requester dropping valid before grant is legal; it is simply not granted.

## Timing
- Reset values:
  - state = IDLE, ptr = 0.
  - o_req_ready = 0, o_rsp_valid = 0, o_rsp_id = 0.
  - o_rsp_eq = 0, o_rsp_gt = 0, o_rsp_lt = 0.
- Accept edge T (IDLE, valid & ready).
- Latency:
  - Early exit: o_rsp_valid first high in cycle T+2.
  - Full two-pass: o_rsp_valid first high in cycle T+3.
- Next accept is possible in the cycle after the response handshake.
- Minimum issue interval: 3 cycles with early exit, 4 cycles without.
- Reset asserted in any state: the in-flight op is dropped with no response. Next cycle is IDLE with ptr = 0.
- Simultaneous requests: exactly one grant per IDLE cycle. Round-robin guarantees each continuously-valid requester is served within NUM_REQ operations.

## Configuration
- PRIM_CMP_SHARE_EARLY_EXIT_EN defined: HI→RESP early exit when high words differ (variable latency, 2 or 3).
- PRIM_CMP_SHARE_EARLY_EXIT_EN undefined: always HI→LO→RESP, constant latency 3.
  - Result uses the HI result if high words differ, else the LO result.
  - Flags are identical to the defined case.

## Structure
- Package prim_cmp_share_pkg:
  - cmp_share_state_e enum (IDLE, HI, LO, RESP).
  - Constants CMP_W = 24 and OP_W = 48.
- Sub-module prim_arb_rr:
  - Parameterised round-robin arbiter.
  - Inputs: request vector, ptr.
  - Outputs: one-hot grant, encoded id.
- Single prim_cmp_mag_24bit instance with muxed operands.

## Test plan
- Req 0 only, a=0x000001_000000, b=0x000000_FFFFFF, unsigned → gt, id 0.
  - Valid at T+2 with EARLY_EXIT_EN, T+3 without.
- a=0x123456_000010, b=0x123456_000020 → lt at T+3.
  - Identical operands 0xABCDEF_012345 → eq at T+3.
- a=0xFFFFFF_FFFFFF, b=0x000000_000001: signed=1 → lt; signed=0 → gt.
- All 4 valid held continuously, i_rsp_ready=1 → response ids 0,1,2,3,0,1, with no repeats before wrap.
- i_rsp_ready low for 5 cycles in RESP → o_rsp_* stable, all o_req_ready = 0. Handshake on the 6th cycle, then the next grant.
- i_rst pulsed while in LO → no o_rsp_valid. Next cycle IDLE; with reqs 2 and 0 pending, requester 0 is granted first.
